mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator that sits between the CPU datapath and the byte-addressed, big-endian `data_mem` word port. It accepts one load or store request at a time, checks alignment and range, and sign- or zero-extends sub-word loads. Sub-word stores go through a read-modify-write sequence, because the memory port always writes four bytes. Each request returns exactly one single-cycle response.

## Interface
Parameters:
- `ENTRIES`, 32: memory size in bytes; must match the attached `data_mem`.
- `ADDR_W`, 5: memory address width; must equal clogb2(ENTRIES-1).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1  sign-extend sub-word loads; ignored for stores and word loads.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  one-cycle response strobe; no backpressure.
- `rsp_rdata`  out  32  load result; 0 for stores and errors; held until the next response.
- `rsp_err`  out  1  request rejected; qualified by `rsp_valid`.
- `mem_addr`  out  ADDR_W  byte address to `data_mem`.
- `mem_rd`  out  1  read enable to `data_mem`.
- `mem_wr`  out  1  write enable; `data_mem` samples it on the falling edge of `clk`.
- `mem_wdata`  out  32  write word, big-endian.
- `mem_rdata`  in  32  combinational read word; high-Z when `mem_rd` is 0.

## Operation
- States: IDLE, RD, WR, RESP. All outputs are registered except `req_ready`, which is decoded as (state == IDLE).
- Request acceptance:
  - A request is accepted on a rising edge with `req_valid` && `req_ready`.
  - At that edge the unit captures we, size, signed, addr and wdata.
  - `mem_addr` is set to req_addr[ADDR_W-1:0].
- Error check at acceptance. Any one of the following sets err and moves IDLE -> RESP with no memory access:
  - size 11;
  - half with addr[0] set;
  - word with addr[1:0] nonzero;
  - req_addr[31:ADDR_W] nonzero;
  - addr + nbytes > ENTRIES, where nbytes is 1, 2 or 4.
- State transitions:
  - IDLE -> WR for a legal word store. `mem_wdata` = req_wdata.
  - IDLE -> RD for a legal load or sub-word store.
  - RD: `mem_rd` = 1 for exactly one cycle; `mem_rdata` is captured at the closing edge. Loads then go to RESP; sub-word stores go to WR.
  - WR: `mem_wr` = 1 for exactly one cycle, `mem_rd` = 0, then RESP.
  - RESP: `rsp_valid` = 1 for one cycle, then IDLE.
- Merge rules (old = captured word):
  - byte store: {wdata[7:0], old[23:0]};
  - half store: {wdata[15:0], old[15:0]}.
- Load extraction:
  - byte: old[31:24] with 24-bit sign or zero extension;
  - half: old[31:16] with 16-bit extension;
  - word: old.
- `mem_rd` and `mem_wr` are never high together, and both are 0 outside RD and WR.
- `mem_addr` holds the last accepted address; reset value 0.

## Timing
- Reset values: state IDLE; `req_ready` 1; `rsp_valid` 0; `rsp_rdata` 0; `rsp_err` 0; `mem_addr` 0; `mem_rd` 0; `mem_wr` 0; `mem_wdata` 0.
- Latency, counted from the acceptance edge E0 to the cycle in which `rsp_valid` is high:
  - error: the cycle after E0;
  - word store: the cycle after E1 (WR is the cycle after E0);
  - load: the cycle after E1 (RD is the cycle after E0);
  - sub-word store: the cycle after E2.
- Throughput: `req_ready` rises in the cycle after RESP. Back-to-back word loads occupy 3 cycles each.
- Reset mid-operation:
  - All state and outputs clear immediately and asynchronously.
  - If reset asserts in RD, no write occurs.
  - If reset asserts in WR before the falling edge, `mem_wr` drops and no write occurs.
  - No response is produced for the aborted request.
- `req_valid` outside IDLE is ignored; the requester must hold it until `req_ready`.

## Test plan
- Word store then load:
  - Store 0xDEADBEEF to addr 8.
  - Required: WR one cycle after acceptance, `mem_wdata` = 0xDEADBEEF, `rsp_err` = 0.
  - Then load word from 8. Required: `rsp_rdata` = 0xDEADBEEF, two cycles after acceptance.
- Byte store RMW:
  - Memory at 8 holds 0xDEADBEEF; store byte 0x12 to 8.
  - Required: RD cycle, then WR with `mem_wdata` = 0x12ADBEEF.
  - Word load from 8 then returns 0x12ADBEEF.
- Sign and zero extension:
  - Word at 4 holds 0x80FF0000.
  - Signed byte load from 4 -> 0xFFFFFF80; unsigned byte load from 4 -> 0x00000080.
  - Signed half load from 4 -> 0xFFFF80FF.
- Errors:
  - Word load at addr 6, half store at 3, word load at 28+4=32, and size 11 each give `rsp_err` = 1 and `rsp_rdata` = 0 one cycle after acceptance.
  - In all four cases `mem_rd` and `mem_wr` never assert.
- Boundary:
  - Word load at 28 with ENTRIES = 32 is legal.
  - Byte store at 31 is legal; it reads and writes the word at 31 and is checked against the 1-byte range only.
- Reset abort:
  - Assert `rst` during the RD cycle of a byte store to 8.
  - Required: `mem_wr` never asserts, outputs go to reset values immediately, `req_ready` = 1 after release, and memory at 8 is unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator for a byte-addressed, big-endian word memory.
// Aligns and range-checks requests, extends sub-word loads, and does RMW for sub-word stores.
module mem_access_unit #(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned EXT_W  = DATA_W + 1;
    localparam int unsigned HALF_W = 16;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [HALF_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [2:0]          nbytes_c;
    logic [EXT_W-1:0]    end_addr_c;
    logic                req_err_c;
    logic [DATA_W-1:0]   load_data_c;
    logic [DATA_W-1:0]   merge_data_c;

    assign req_ready = (state_q == IDLE);

    // Request legality: size, alignment, upper address bits and end-of-access range.
    always_comb begin
        case (req_size)
            SIZE_BYTE: nbytes_c = 3'd1;
            SIZE_HALF: nbytes_c = 3'd2;
            default:   nbytes_c = 3'd4;
        endcase
        end_addr_c = EXT_W'(req_addr) + EXT_W'(nbytes_c);
        req_err_c  = (req_size == SIZE_ILL)
                   | ((req_size == SIZE_HALF) & req_addr[0])
                   | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00))
                   | (|req_addr[DATA_W-1:ADDR_W])
                   | (end_addr_c > EXT_W'(ENTRIES));
    end

    // Big-endian: the addressed byte is the most significant byte of the read word.
    always_comb begin
        case (size_q)
            SIZE_BYTE: load_data_c = {{24{signed_q & mem_rdata[31]}}, mem_rdata[31:24]};
            SIZE_HALF: load_data_c = {{16{signed_q & mem_rdata[31]}}, mem_rdata[31:16]};
            default:   load_data_c = mem_rdata;
        endcase
        if (size_q == SIZE_BYTE) begin
            merge_data_c = {wdata_q[7:0], mem_rdata[23:0]};
        end else begin
            merge_data_c = {wdata_q, mem_rdata[15:0]};
        end
    end

    // Next state; strobes are computed for the state being entered so they are registered.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    size_d     = req_size;
                    signed_d   = req_signed;
                    wdata_d    = req_wdata[HALF_W-1:0];
                    mem_addr_d = req_addr[ADDR_W-1:0];
                    if (req_err_c) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end else if (req_we && (req_size == SIZE_WORD)) begin
                        mem_wdata_d = req_wdata;
                        mem_wr_d    = 1'b1;
                        state_d     = WR;
                    end else begin
                        mem_rd_d = 1'b1;
                        state_d  = RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    mem_wdata_d = merge_data_c;
                    mem_wr_d    = 1'b1;
                    state_d     = WR;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data_c;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end
            end
            WR: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                state_d     = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random requests against a byte-array model.
module tb_mem_access_unit;
    localparam int unsigned ENTRIES = 32;
    localparam int unsigned ADDR_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_signed = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    mem_access_unit #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Attached memory (the bench's data_mem) and the reference model's view of it.
    logic [7:0] mem_b [ENTRIES];
    logic [7:0] ref_b [ENTRIES];
    logic [7:0] seed_b [ENTRIES];
    logic       mem_init = 1'b0;

    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < ENTRIES; i++) mem_b[i] <= seed_b[i];
        end else if (mem_wr) begin
            for (int i = 0; i < 4; i++)
                if (int'(mem_addr) + i < ENTRIES) mem_b[int'(mem_addr) + i] <= mem_wdata[31 - 8*i -: 8];
        end
    end

    // Garbage when not reading, so a DUT sampling outside RD is exposed.
    always_comb begin
        mem_rdata = 32'hA5A5_A5A5;
        if (mem_rd) begin
            for (int i = 0; i < 4; i++)
                mem_rdata[31 - 8*i -: 8] = (int'(mem_addr) + i < ENTRIES) ? mem_b[int'(mem_addr) + i] : 8'h00;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_err(input logic [1:0] size, input logic [31:0] addr);
        int nb;
        if (size == 2'd3) return 1'b1;
        nb = nbytes(size);
        if (longint'(addr) % nb != 0) return 1'b1;
        if (longint'(addr) + nb > longint'(ENTRIES)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[31 - 8*i -: 8] = (a + i < ENTRIES) ? ref_b[a + i] : 8'h00;
        return w;
    endfunction

    function automatic logic [31:0] load_val(input logic [1:0] size, input bit sgn, input int a);
        longint v;
        int nb;
        nb = nbytes(size);
        v  = 0;
        for (int i = 0; i < nb; i++) v = v * 256 + longint'(ref_b[a + i]);
        if (sgn && nb < 4 && v >= (longint'(1) << (8*nb - 1))) v = v - (longint'(1) << (8*nb));
        return 32'(v);
    endfunction

    // One request, observed cycle by cycle after the acceptance edge.
    task automatic do_req(input string tag, input bit we, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        bit          err;
        int          nb, lat, exp_rd_at, exp_wr_at;
        int          rd_at, wr_at, rd_cnt, wr_cnt, both, rsp_at;
        logic [31:0] exp_rdata, exp_wdata, wd_seen, rdata_seen, addr_seen;
        logic        err_seen;

        err = is_err(size, addr);
        nb  = nbytes(size);
        exp_rdata = '0;
        exp_wdata = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) ref_b[int'(addr) + i] = wdata[8*(nb-1-i) +: 8];
                exp_wdata = ref_word(int'(addr));
            end else begin
                exp_rdata = load_val(size, sgn, int'(addr));
            end
        end
        lat       = err ? 1 : (we && size != 2'd2) ? 3 : 2;
        exp_rd_at = (err || (we && size == 2'd2)) ? 0 : 1;
        exp_wr_at = (err || !we) ? 0 : (size == 2'd2) ? 1 : 2;

        @(negedge clk);
        check({tag, ":ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = hold; req_we = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

        rd_at = 0; wr_at = 0; rd_cnt = 0; wr_cnt = 0; both = 0; rsp_at = 0;
        wd_seen = '0; rdata_seen = '0; err_seen = 1'b0; addr_seen = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) addr_seen = 32'(mem_addr);
            if (mem_rd) begin rd_cnt++; if (rd_at == 0) rd_at = n; end
            if (mem_wr) begin wr_cnt++; if (wr_at == 0) wr_at = n; wd_seen = mem_wdata; end
            if (mem_rd && mem_wr) both++;
            if (rsp_valid) begin
                rsp_at = n; rdata_seen = rsp_rdata; err_seen = rsp_err;
                break;
            end
        end
        req_valid = 1'b0;

        check({tag, ":latency"}, 32'(rsp_at), 32'(lat));
        check({tag, ":mem_addr"}, addr_seen, 32'(addr[ADDR_W-1:0]));
        check({tag, ":rd_cycles"}, 32'(rd_cnt), 32'(exp_rd_at != 0));
        check({tag, ":wr_cycles"}, 32'(wr_cnt), 32'(exp_wr_at != 0));
        check({tag, ":rd_at"}, 32'(rd_at), 32'(exp_rd_at));
        check({tag, ":wr_at"}, 32'(wr_at), 32'(exp_wr_at));
        check({tag, ":rd_wr_overlap"}, 32'(both), 32'd0);
        if (exp_wr_at != 0) check({tag, ":wdata"}, wd_seen, exp_wdata);
        check({tag, ":err"}, 32'(err_seen), 32'(err));
        check({tag, ":rdata"}, rdata_seen, exp_rdata);
        @(negedge clk);
        check({tag, ":rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
        check({tag, ":rdata_held"}, rsp_rdata, exp_rdata);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
        check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ":rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, ":rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, ":mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, ":mem_rd"}, 32'(mem_rd), 32'd0);
        check({tag, ":mem_wr"}, 32'(mem_wr), 32'd0);
        check({tag, ":mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int bad;
        logic [31:0] a;

        for (int i = 0; i < ENTRIES; i++) begin
            seed_b[i] = 8'($urandom);
            ref_b[i]  = seed_b[i];
        end
        #2 rst = 1'b1;
        #2 check_reset_outputs("reset");
        mem_init = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        rst = 1'b0;

        do_req("st_word8", 1'b1, 2'd2, 1'b0, 32'd8, 32'hDEAD_BEEF, 1'b0);
        do_req("ld_word8", 1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 1'b0);
        do_req("st_byte8", 1'b1, 2'd0, 1'b0, 32'd8, 32'h0000_0012, 1'b0);
        do_req("ld_word8b", 1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 1'b0);
        check("rmw_value", ref_word(8), 32'h12AD_BEEF);
        do_req("st_word4", 1'b1, 2'd2, 1'b0, 32'd4, 32'h80FF_0000, 1'b0);
        do_req("ld_sbyte4", 1'b0, 2'd0, 1'b1, 32'd4, 32'h0, 1'b0);
        do_req("ld_ubyte4", 1'b0, 2'd0, 1'b0, 32'd4, 32'h0, 1'b0);
        do_req("ld_shalf4", 1'b0, 2'd1, 1'b1, 32'd4, 32'h0, 1'b0);
        check("sext_byte", load_val(2'd0, 1'b1, 4), 32'hFFFF_FF80);
        check("sext_half", load_val(2'd1, 1'b1, 4), 32'hFFFF_80FF);
        do_req("err_word6", 1'b0, 2'd2, 1'b0, 32'd6, 32'h0, 1'b0);
        do_req("err_half3", 1'b1, 2'd1, 1'b0, 32'd3, 32'h1234, 1'b0);
        do_req("err_word32", 1'b0, 2'd2, 1'b0, 32'd32, 32'h0, 1'b0);
        do_req("err_size3", 1'b0, 2'd3, 1'b0, 32'd0, 32'h0, 1'b0);
        do_req("err_hiaddr", 1'b0, 2'd0, 1'b0, 32'h0001_0004, 32'h0, 1'b0);
        do_req("ld_word28", 1'b0, 2'd2, 1'b0, 32'd28, 32'h0, 1'b0);
        do_req("st_byte31", 1'b1, 2'd0, 1'b0, 32'd31, 32'h0000_005A, 1'b0);
        do_req("ld_byte31", 1'b0, 2'd0, 1'b1, 32'd31, 32'h0, 1'b0);
        do_req("err_half31", 1'b0, 2'd1, 1'b0, 32'd31, 32'h0, 1'b0);

        // Reset asserted during the RD cycle of a byte store must leave memory alone.
        do_req("pre_abort", 1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'd8; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort:in_rd", 32'(mem_rd), 32'd1);
        rst = 1'b1;
        #1 check_reset_outputs("abort");
        bad = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (mem_wr || rsp_valid) bad++;
        end
        check("abort:no_wr_no_rsp", 32'(bad), 32'd0);
        check("abort:ready", 32'(req_ready), 32'd1);
        check("abort:mem8", {mem_b[8], mem_b[9], mem_b[10], mem_b[11]}, ref_word(8));

        for (int t = 0; t < 150; t++) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 35));
            do_req("rand", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                   1'($urandom));
        end

        for (int w = 0; w < ENTRIES; w += 4)
            check("final_mem", {mem_b[w], mem_b[w+1], mem_b[w+2], mem_b[w+3]}, ref_word(w));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
